// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter sharing one single-port memory; round-robin by default, MEM_ARB_FIXED_PRIO_EN selects fixed priority
module mem_arbiter #(
    parameter int addr_width = 8,
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_write,
    input  logic [addr_width-1:0] p0_addr,
    input  logic [data_width-1:0] p0_wdata,
    output logic [data_width-1:0] p0_rdata,
    output logic                  p0_ack,
    input  logic                  p1_req,
    input  logic                  p1_write,
    input  logic [addr_width-1:0] p1_addr,
    input  logic [data_width-1:0] p1_wdata,
    output logic [data_width-1:0] p1_rdata,
    output logic                  p1_ack,
    output logic                  mem_write,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    output logic [1:0]            grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t state;
    logic   sel;
    logic   winner;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Port 0 takes every tie; port 1 only wins when it asks alone.
    assign winner = p1_req && !p0_req;
`else
    logic last;

    // On a tie the port that was not served most recently wins.
    always_comb begin
        winner = 1'b0;
        if (p0_req && p1_req)
            winner = ~last;
        else if (p1_req)
            winner = 1'b1;
    end
`endif

    always_comb begin
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ACC) begin
            if (sel) begin
                mem_write = p1_write;
                mem_addr  = p1_addr;
                mem_wdata = p1_wdata;
            end else begin
                mem_write = p0_write;
                mem_addr  = p0_addr;
                mem_wdata = p0_wdata;
            end
        end
    end

    assign grant = (state == IDLE) ? 2'b00 : (sel ? 2'b10 : 2'b01);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            last     <= 1'b1;
`endif
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        sel   <= winner;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (sel) begin
                        p1_ack <= 1'b1;
                        if (!p1_write)
                            p1_rdata <= mem_rdata;
                    end else begin
                        p0_ack <= 1'b1;
                        if (!p0_write)
                            p0_rdata <= mem_rdata;
                    end
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last  <= sel;
`endif
                    state <= ACK;
                end
                ACK: begin
                    // The served master is still looking at ack, so only the other port counts.
                    if (sel ? p0_req : p1_req) begin
                        sel   <= ~sel;
                        state <= ACC;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter: vector table, corner sequences, randomized traffic vs reference model
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_req, p0_write, p1_req, p1_write;
    logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [7:0] p0_rdata, p1_rdata;
    logic       p0_ack, p1_ack;
    logic       mem_write;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0] grant;

    logic [7:0] mem [0:255];

    mem_arbiter #(.addr_width(8), .data_width(8)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r0, w0;
        logic [7:0] a0, d0;
        logic       r1, w1;
        logic [7:0] a1, d1;
        logic [1:0] g, ack;
        logic       mw;
        logic [7:0] ma;
        logic       chk_rd;
        logic [7:0] rd0;
    } vec_t;

    function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, d0,
                                input logic r1, w1, input logic [7:0] a1, d1,
                                input logic [1:0] g, ack, input logic mw,
                                input logic [7:0] ma, input logic chk_rd, input logic [7:0] rd0);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.g = g; v.ack = ack; v.mw = mw; v.ma = ma; v.chk_rd = chk_rd; v.rd0 = rd0;
        return v;
    endfunction

    vec_t vecs [11];

    logic       preq [2];
    logic       pwr  [2];
    logic [7:0] paddr[2];
    logic [7:0] pwd  [2];
    logic [7:0] last_rd [2];
    int         waitc [2];
    int         served_other [2];
    logic [7:0] ref_mem [0:255];

    task automatic apply_ports;
        p0_req = preq[0]; p0_write = pwr[0]; p0_addr = paddr[0]; p0_wdata = pwd[0];
        p1_req = preq[1]; p1_write = pwr[1]; p1_addr = paddr[1]; p1_wdata = pwd[1];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, prev;
        logic [1:0] ack;
        logic [7:0] rd [2];

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
        p0_req = 0; p0_write = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_write = 0; p1_addr = 0; p1_wdata = 0;
        rst = 1;
        step; step;
        check("reset_grant", grant, 2'b00);
        check("reset_ack", {p1_ack, p0_ack}, 2'b00);
        check("reset_rdata", {p1_rdata, p0_rdata}, 16'h0);
        check("reset_mem_write", mem_write, 1'b0);
        rst = 0;

        // Asynchronous reset landing mid-ACC
        p0_req = 1; p0_addr = 8'h05;
        step;
        check("pre_rst_grant", grant, 2'b01);
        #2 rst = 1;
        #1;
        check("async_rst_grant", grant, 2'b00);
        check("async_rst_mem_addr", mem_addr, 8'h00);
        check("async_rst_ack", {p1_ack, p0_ack}, 2'b00);
        check("async_rst_rdata", p0_rdata, 8'h00);
        p0_req = 0; p0_addr = 0;
        @(posedge clk); #1;
        rst = 0;

        vecs[0]  = mk(1, 0, 8'h01, 8'h00, 1, 1, 8'h02, 8'hA5, 2'b01, 2'b00, 0, 8'h01, 0, 8'h00);
        vecs[1]  = mk(1, 0, 8'h01, 8'h00, 1, 1, 8'h02, 8'hA5, 2'b01, 2'b01, 0, 8'h00, 1, 8'h3D);
        vecs[2]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'hA5, 2'b10, 2'b00, 1, 8'h02, 0, 8'h00);
        vecs[3]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h02, 8'hA5, 2'b10, 2'b10, 0, 8'h00, 1, 8'h3D);
        vecs[4]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 0, 8'h00);
        vecs[5]  = mk(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 1, 8'h10, 0, 8'h00);
        vecs[6]  = mk(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 0, 8'h00, 0, 8'h00);
        vecs[7]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 0, 8'h00);
        vecs[8]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b00, 0, 8'h10, 0, 8'h00);
        vecs[9]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 2'b01, 2'b01, 0, 8'h00, 1, 8'h5A);
        vecs[10] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 2'b00, 2'b00, 0, 8'h00, 0, 8'h00);

        for (int i = 0; i < 11; i++) begin
            p0_req = vecs[i].r0; p0_write = vecs[i].w0; p0_addr = vecs[i].a0; p0_wdata = vecs[i].d0;
            p1_req = vecs[i].r1; p1_write = vecs[i].w1; p1_addr = vecs[i].a1; p1_wdata = vecs[i].d1;
            step;
            check($sformatf("vec%0d_grant", i), grant, vecs[i].g);
            check($sformatf("vec%0d_ack", i), {p1_ack, p0_ack}, vecs[i].ack);
            check($sformatf("vec%0d_mem_write", i), mem_write, vecs[i].mw);
            check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].ma);
            if (vecs[i].chk_rd) check($sformatf("vec%0d_p0_rdata", i), p0_rdata, vecs[i].rd0);
        end
        check("p1_write_committed", mem[8'h02], 8'hA5);

        // Port 1 alone, request held: one access every 3 cycles
        p1_req = 1; p1_write = 0; p1_addr = 8'h03;
        for (int c = 1; c <= 9; c++) begin
            step;
            if (c == 9) p1_req = 0;
            check($sformatf("p1_burst_c%0d_ack1", c), p1_ack, (c % 3 == 2) ? 1'b1 : 1'b0);
            check($sformatf("p1_burst_c%0d_ack0", c), p0_ack, 1'b0);
        end
        check("p1_burst_rdata", p1_rdata, 8'h3F);
        step;

        // Both ports always requesting: strict alternation
        p0_req = 1; p0_write = 0; p0_addr = 8'h04;
        p1_req = 1; p1_write = 0; p1_addr = 8'h06;
        n = 0; prev = -1;
        for (int c = 0; c < 40 && n < 8; c++) begin
            step;
            check("alt_ack_exclusive", p0_ack & p1_ack, 1'b0);
            if (p0_ack || p1_ack) begin
                if (prev >= 0) check($sformatf("alt_ack%0d_port", n), p1_ack, prev == 0 ? 1'b1 : 1'b0);
                prev = p1_ack ? 1 : 0;
                n++;
            end
        end
        check("alt_ack_count", n, 8);
        p0_req = 0; p1_req = 0;
        step; step;

        // Reset during a write's ACC cycle must suppress the commit
        p0_req = 1; p0_write = 1; p0_addr = 8'h20; p0_wdata = 8'hEE;
        step;
        check("rst_acc_mem_write", mem_write, 1'b1);
        #2 rst = 1;
        #1;
        check("rst_acc_mem_write_drop", mem_write, 1'b0);
        p0_req = 0; p0_write = 0;
        @(posedge clk); #1;
        rst = 0;
        p0_req = 1; p0_addr = 8'h20;
        step; step;
        check("rst_acc_read_ack", p0_ack, 1'b1);
        check("rst_acc_read_data", p0_rdata, 8'h1C);
        p0_req = 0;
        step;

        // Randomized traffic against a transaction-level reference
        rst = 1; step; rst = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int p = 0; p < 2; p++) begin
            preq[p] = 0; pwr[p] = 0; paddr[p] = 0; pwd[p] = 0;
            last_rd[p] = 0; waitc[p] = 0; served_other[p] = 0;
        end
        apply_ports;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step;
            ack = {p1_ack, p0_ack};
            rd[0] = p0_rdata; rd[1] = p1_rdata;
            check("rnd_ack_exclusive", ack[0] & ack[1], 1'b0);
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    check("rnd_ack_without_req", preq[p], 1'b1);
                    if (pwr[p]) ref_mem[paddr[p]] = pwd[p];
                    else begin
                        check($sformatf("rnd_p%0d_read", p), rd[p], ref_mem[paddr[p]]);
                        last_rd[p] = ref_mem[paddr[p]];
                    end
                    check($sformatf("rnd_p%0d_fairness", p), served_other[p] <= 1, 1'b1);
                    check($sformatf("rnd_p%0d_latency", p), waitc[p] <= 6, 1'b1);
                    served_other[p] = 0;
                    if (preq[1-p]) served_other[1-p]++;
                end else if (preq[p]) begin
                    waitc[p]++;
                end
                check($sformatf("rnd_p%0d_rdata_hold", p), rd[p], last_rd[p]);
            end
            if (waitc[0] > 50 || waitc[1] > 50) begin
                check("rnd_no_deadlock", 1'b0, 1'b1);
                break;
            end
            for (int p = 0; p < 2; p++) begin
                if (!preq[p] || ack[p]) begin
                    waitc[p] = 0;
                    if ($urandom_range(0, 2) != 0) begin
                        preq[p]  = 1;
                        pwr[p]   = 1'($urandom_range(0, 1));
                        paddr[p] = 8'($urandom_range(0, 15));
                        pwd[p]   = 8'($urandom_range(0, 255));
                    end else begin
                        preq[p] = 0;
                    end
                end
            end
            apply_ports;
        end
        preq[0] = 0; preq[1] = 0;
        apply_ports;
        step; step; step;
        check("rnd_end_idle", grant, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
